can_form_checker: RTL

Parametrised form-error monitor for the CAN controller. Watches every fixed-form field (CRC delimiter, ACK delimiter, EOF, error delimiter, overload delimiter) at the bit sample point. Flags any dominant bit where the protocol requires recessive. Provides a stretched error pulse, the offending field and bit position, a saturating error count, and the receiver-side EOF last-bit overload exception. Sits beside the bit-stream decoder, consuming its frame-field code and sampled bit; outputs feed the error-frame generator and error counters.

---
 rtl/can_pkg.sv | 24 ++
 rtl/can_form_checker_if.sv | 33 +++
 rtl/can_field_bit_counter.sv | 40 ++++
 rtl/can_form_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// CAN frame-field codes, field lengths and form-checker FSM states.
// Shared by the form, stuff and bit-error monitors.
package can_pkg;

  localparam logic [4:0] FIELD_CRC_DELIM = 5'b10001;
  localparam logic [4:0] FIELD_ACK_DELIM = 5'b10010;
  localparam logic [4:0] FIELD_EOF       = 5'b10011;
  localparam logic [4:0] FIELD_ERR_DELIM = 5'b10100;
  localparam logic [4:0] FIELD_OVL_DELIM = 5'b10101;

  localparam logic [3:0] LEN_CRC_DELIM = 4'd1;
  localparam logic [3:0] LEN_ACK_DELIM = 4'd1;
  localparam logic [3:0] LEN_EOF       = 4'd7;
  localparam logic [3:0] LEN_ERR_DELIM = 4'd8;
  localparam logic [3:0] LEN_OVL_DELIM = 4'd8;

  localparam logic [3:0] EOF_LAST_BIT = 4'd6;

  typedef enum logic {
    IDLE,
    FLAG
  } form_state_e;

endpackage

// File: rtl/can_form_checker_if.sv
// Decoder-side bundle into the CAN form checker and its reported results.
// master = decoder/consumer side, slave = checker.
interface can_form_checker_if #(
  parameter int FIELD_W = 5,
  parameter int CNT_W   = 8
) ();

  logic               i_Sample;
  logic               i_Data;
  logic [FIELD_W-1:0] i_frame_field;
  logic [4:0]         i_Enable_mask;
  logic               i_Clear;
  logic               o_form_error;
  logic [FIELD_W-1:0] o_form_field;
  logic [3:0]         o_form_bit;
  logic               o_overload;
  logic [CNT_W-1:0]   o_error_count;

  modport master (
    output i_Sample, i_Data, i_frame_field,
    output i_Enable_mask, i_Clear,
    input  o_form_error, o_form_field, o_form_bit,
    input  o_overload, o_error_count
  );

  modport slave (
    input  i_Sample, i_Data, i_frame_field,
    input  i_Enable_mask, i_Clear,
    output o_form_error, o_form_field, o_form_bit,
    output o_overload, o_error_count
  );

endinterface

// File: rtl/can_field_bit_counter.sv
// Tracks the bit position inside the current frame field.
// o_idx is the index of the sample being taken this cycle.
module can_field_bit_counter #(
  parameter int FIELD_W = 5
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Sample,
  input  logic [FIELD_W-1:0] i_field,
  output logic [3:0]         o_idx
);

  logic [FIELD_W-1:0] prev_q;
  logic [3:0]         idx_q;
  logic [3:0]         idx_d;

  // A field change counts from zero on its first sample, even
  // when the change and the strobe land in the same cycle.
  always_comb begin
    idx_d = idx_q;
    if (i_field != prev_q) begin
      idx_d = 4'd0;
    end else if (idx_q != 4'd15) begin
      idx_d = idx_q + 4'd1;
    end
  end

  assign o_idx = idx_d;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      prev_q <= '0;
      idx_q  <= 4'd0;
    end else if (i_Sample) begin
      prev_q <= i_field;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/can_form_checker.sv
// CAN form-error monitor: flags dominant bits in fixed-form fields,
// stretches the flag, captures field/bit and counts errors.
module can_form_checker
  import can_pkg::*;
#(
  parameter int FIELD_W   = 5,
  parameter int HOLD_CLKS = 10,
  parameter int CNT_W     = 8,
  parameter int RX_MODE   = 1
) (
  input logic              i_Clock,
  input logic              i_Reset,
  can_form_checker_if.slave bus
);

  localparam int HW = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam bit RX_EOF_EXC = (RX_MODE != 0);

  logic [3:0]         idx;
  logic [4:0]         sel;
  logic [3:0]         len;
  logic               chk;
  logic               ovl_hit;
  logic               err;
  logic [CNT_W-1:0]   cnt_d;

  form_state_e        state_q;
  logic [HW-1:0]      hold_q;
  logic               ferr_q;
  logic               ovl_q;
  logic [FIELD_W-1:0] field_q;
  logic [3:0]         bit_q;
  logic [CNT_W-1:0]   cnt_q;

  can_field_bit_counter #(
    .FIELD_W(FIELD_W)
  ) u_bitcnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Sample(bus.i_Sample),
    .i_field (bus.i_frame_field),
    .o_idx   (idx)
  );

  always_comb begin
    sel = 5'b00000;
    len = 4'd0;
    unique case (1'b1)
      (bus.i_frame_field == FIELD_W'(FIELD_CRC_DELIM)): begin
        sel = 5'b00001;
        len = LEN_CRC_DELIM;
      end
      (bus.i_frame_field == FIELD_W'(FIELD_ACK_DELIM)): begin
        sel = 5'b00010;
        len = LEN_ACK_DELIM;
      end
      (bus.i_frame_field == FIELD_W'(FIELD_EOF)): begin
        sel = 5'b00100;
        len = LEN_EOF;
      end
      (bus.i_frame_field == FIELD_W'(FIELD_ERR_DELIM)): begin
        sel = 5'b01000;
        len = LEN_ERR_DELIM;
      end
      (bus.i_frame_field == FIELD_W'(FIELD_OVL_DELIM)): begin
        sel = 5'b10000;
        len = LEN_OVL_DELIM;
      end
      default: ;
    endcase
  end

  assign chk = (|(sel & bus.i_Enable_mask)) && (idx < len);

  // A receiver treats a dominant last EOF bit as an overload request.
  assign ovl_hit = bus.i_Sample && RX_EOF_EXC && sel[2]
                 && bus.i_Enable_mask[2]
                 && (idx == EOF_LAST_BIT) && !bus.i_Data;

  assign err = bus.i_Sample && chk && !bus.i_Data && !ovl_hit;

  always_comb begin
    cnt_d = cnt_q;
    if (err) begin
      if (bus.i_Clear) begin
        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.i_Clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ferr_q  <= 1'b0;
      ovl_q   <= 1'b0;
      field_q <= '0;
      bit_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      ovl_q <= ovl_hit;
      cnt_q <= cnt_d;
      if (err) begin
        field_q <= bus.i_frame_field;
        bit_q   <= idx;
      end else if (bus.i_Clear) begin
        field_q <= '0;
        bit_q   <= 4'd0;
      end
      case (state_q)
        IDLE: begin
          if (err) begin
            state_q <= FLAG;
            hold_q  <= HOLD_RELOAD;
            ferr_q  <= 1'b1;
          end
        end
        FLAG: begin
          if (err) begin
            hold_q <= HOLD_RELOAD;
          end else if (hold_q == '0) begin
            state_q <= IDLE;
            ferr_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ferr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_form_error  = ferr_q;
  assign bus.o_overload    = ovl_q;
  assign bus.o_form_field  = field_q;
  assign bus.o_form_bit    = bit_q;
  assign bus.o_error_count = cnt_q;

endmodule
